apb_to_obi_bridge: RTL and testbench
====================================

# apb_to_obi_bridge

APB completer that converts each APB transfer into exactly one OBI request/response and completes the APB access when the OBI response returns. It is the reverse of the peripheral OBI-to-APB split: subsystems or off-chip debug masters that speak APB use it to reach the OBI interconnect as an OBI initiator. One transfer is in flight at a time, and there is no buffering beyond a single captured request and response.

## Interface
- APB_AW, 32, APB address width
- APB_DW, 32, APB data width; must equal OBI_DW
- OBI_AW, 32, OBI address width; PADDR is zero-extended or truncated to it
- OBI_DW, 32, OBI data width
- OBI_IDW, 1, OBI id width
- WIN_BASE, 32'h0103_0000, first byte of the accepted address window (used only with the window check enabled)
- WIN_SIZE, 32'h400, window size in bytes

Ports:
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high; fixed by design
- APB_PADDR  in  APB_AW  address
- APB_PSEL  in  1  select
- APB_PENABLE  in  1  access phase
- APB_PWRITE  in  1  1 = write
- APB_PWDATA  in  APB_DW  write data
- APB_PSTRB  in  APB_DW/8  byte strobes
- APB_PRDATA  out  APB_DW  read data
- APB_PREADY  out  1  completes the access phase
- APB_PSLVERR  out  1  error, valid only with PREADY
- obi_req  out  1  request
- obi_gnt  in  1  grant
- obi_addr  out  OBI_AW  address
- obi_we  out  1  write enable
- obi_be  out  OBI_DW/8  byte enables
- obi_wdata  out  OBI_DW  write data
- obi_aid  out  OBI_IDW  constant 0
- obi_rvalid  in  1  response valid
- obi_rready  out  1  response ready
- obi_rdata  in  OBI_DW  response data
- obi_err  in  1  response error
- obi_rid  in  OBI_IDW  ignored, because only one transaction is outstanding

## Operation
- FSM states: IDLE, REQ, RSP, DONE.
- **IDLE**
  - On PSEL=1 and PENABLE=0 (setup phase), register PADDR, PWRITE, PWDATA and PSTRB, then go to REQ.
  - All outputs are 0 in this state.
- **REQ**
  - obi_req=1. obi_addr, obi_we and obi_wdata come from the registered fields.
  - obi_be = PSTRB for writes, all-ones for reads.
  - The captured fields hold stable until grant. obi_req never drops before obi_gnt.
  - On obi_gnt, go to RSP.
- **RSP**
  - obi_rready=1 and obi_req=0.
  - On obi_rvalid, register obi_rdata (reads only; writes capture 0) and obi_err, then go to DONE.
- **DONE**
  - APB_PREADY=1 for exactly one cycle.
  - APB_PRDATA = captured data; APB_PSLVERR = captured obi_err.
  - Always returns to IDLE next cycle.
- Outside DONE, APB_PREADY, APB_PRDATA and APB_PSLVERR are all 0.
- Back-to-back transfers: a setup phase in the cycle right after DONE is accepted from IDLE normally.
- PSEL dropped mid-transfer (APB violation): the OBI transaction still completes and the PREADY pulse is issued and ignored. No state leaks into the next transfer.
- Reset asserted mid-operation: asynchronous return to IDLE, all outputs 0 immediately.
  - If obi_req was high, it drops without a grant. This is accepted; the system resets the interconnect together with the bridge.

## Timing
- Reset values: every output 0, state IDLE.
- Minimum transfer (setup in cycle T0):
  - REQ in T1 with gnt in T1.
  - rvalid in T2.
  - PREADY in T3.
  - That is 2 wait states and 4 cycles total.
- Each grant-wait cycle and each rvalid-wait cycle adds one wait state.
- obi_rvalid in the same cycle as obi_gnt cannot occur (OBI rule) and is not sampled in REQ.

## Configuration
- APB_TO_OBI_WIN_CHECK_EN defined:
  - In IDLE, a setup phase with PADDR outside [WIN_BASE, WIN_BASE+WIN_SIZE) goes directly to DONE with APB_PSLVERR=1 and APB_PRDATA=0.
  - No OBI request is issued, so PREADY comes in T1 (zero wait states).
  - The comparison is unsigned, and WIN_BASE+WIN_SIZE is computed at APB_AW+1 bits so the window's end does not wrap.
- Not defined: every address is forwarded and no window logic is synthesized.

## Structure
- Shared package obi_apb_pkg: the state enum typedef, a localparam for the default window base and size, and the rule that APB_DW equals OBI_DW.
- Single module. The window comparator is the only natural sub-module: apb_addr_window_chk, instantiated only under the macro.

## Test plan
- Read at 0x0103_0010, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF -> PREADY in T3, PRDATA=0xDEADBEEF, PSLVERR=0, obi_be=4'hF, obi_we=0.
- Write 0x1234_5678 with PSTRB=4'b0011, gnt held low 3 cycles -> obi_req stays high with stable addr/wdata/be=4'b0011 until gnt; PREADY 3 cycles later than the minimum.
- Read with obi_err=1 in the response -> PSLVERR=1 with PREADY, PRDATA=0.
- Two back-to-back reads -> the second setup in the cycle after PREADY is accepted; exactly two OBI grants, with no extra or missing requests.
- Reset asserted in RSP -> all outputs 0 in the same cycle; the next transfer completes normally.
- With APB_TO_OBI_WIN_CHECK_EN, read at 0x0103_0400 -> PREADY in T1 with PSLVERR=1 and obi_req never high. At 0x0103_03FC -> the request is forwarded.

Source files
------------

// File: rtl/obi_apb_pkg.sv
// Shared definitions for the APB-to-OBI bridge: FSM state encoding, the
// default address window, and the data-width equality rule.
package obi_apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } bridge_state_t;

    localparam logic [31:0] WIN_BASE_DEFAULT = 32'h0103_0000;
    localparam logic [31:0] WIN_SIZE_DEFAULT = 32'h0000_0400;

    // APB data passes straight through to OBI, so both buses must be equally wide.
    function automatic bit data_widths_match(input int apb_dw, input int obi_dw);
        return apb_dw == obi_dw;
    endfunction

endpackage

// File: rtl/apb_addr_window_chk.sv
// Unsigned address window comparator. The upper bound is formed one bit
// wider than the address so a window ending at the top of the space does
// not wrap to zero.
module apb_addr_window_chk #(
    parameter int unsigned    AW   = 32,
    parameter logic [AW-1:0]  BASE = '0,
    parameter logic [AW-1:0]  SIZE = '0
) (
    input  logic [AW-1:0] addr,
    output logic          in_window
);

    localparam logic [AW:0] LOW  = {1'b0, BASE};
    localparam logic [AW:0] HIGH = {1'b0, BASE} + {1'b0, SIZE};

    logic [AW:0] addr_ext;

    assign addr_ext  = {1'b0, addr};
    assign in_window = (addr_ext >= LOW) && (addr_ext < HIGH);

endmodule

// File: rtl/apb_to_obi_bridge.sv
// APB completer that turns each APB transfer into a single OBI
// request/response. Only one transfer is in flight at a time.
// Optional feature: define APB_TO_OBI_WIN_CHECK_EN to reject addresses
// outside [WIN_BASE, WIN_BASE+WIN_SIZE) with PSLVERR and no OBI request.
module apb_to_obi_bridge
    import obi_apb_pkg::*;
#(
    parameter int unsigned        APB_AW   = 32,
    parameter int unsigned        APB_DW   = 32,
    parameter int unsigned        OBI_AW   = 32,
    parameter int unsigned        OBI_DW   = 32,
    parameter int unsigned        OBI_IDW  = 1,
    parameter logic [APB_AW-1:0]  WIN_BASE = APB_AW'(WIN_BASE_DEFAULT),
    parameter logic [APB_AW-1:0]  WIN_SIZE = APB_AW'(WIN_SIZE_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [APB_AW-1:0]     APB_PADDR,
    input  logic                  APB_PSEL,
    input  logic                  APB_PENABLE,
    input  logic                  APB_PWRITE,
    input  logic [APB_DW-1:0]     APB_PWDATA,
    input  logic [APB_DW/8-1:0]   APB_PSTRB,
    output logic [APB_DW-1:0]     APB_PRDATA,
    output logic                  APB_PREADY,
    output logic                  APB_PSLVERR,
    output logic                  obi_req,
    input  logic                  obi_gnt,
    output logic [OBI_AW-1:0]     obi_addr,
    output logic                  obi_we,
    output logic [OBI_DW/8-1:0]   obi_be,
    output logic [OBI_DW-1:0]     obi_wdata,
    output logic [OBI_IDW-1:0]    obi_aid,
    input  logic                  obi_rvalid,
    output logic                  obi_rready,
    input  logic [OBI_DW-1:0]     obi_rdata,
    input  logic                  obi_err,
    input  logic [OBI_IDW-1:0]    obi_rid
);

    if (!data_widths_match(APB_DW, OBI_DW)) begin : g_dw_mismatch
        $error("apb_to_obi_bridge: APB_DW must equal OBI_DW");
    end

    localparam int unsigned CW = (OBI_AW < APB_AW) ? OBI_AW : APB_AW;

    bridge_state_t          state_q, state_d;
    logic [APB_AW-1:0]      addr_q;
    logic                   we_q;
    logic [APB_DW-1:0]      wdata_q;
    logic [APB_DW/8-1:0]    strb_q;
    logic [APB_DW-1:0]      rdata_q;
    logic                   err_q;
    logic                   setup;
    logic                   in_window;
    logic [OBI_AW-1:0]      addr_ext;
    logic [OBI_IDW-1:0]     unused_rid;

    assign setup      = APB_PSEL && !APB_PENABLE;
    assign obi_aid    = '0;
    assign unused_rid = obi_rid;

`ifdef APB_TO_OBI_WIN_CHECK_EN
    apb_addr_window_chk #(
        .AW   (APB_AW),
        .BASE (WIN_BASE),
        .SIZE (WIN_SIZE)
    ) u_win_chk (
        .addr      (APB_PADDR),
        .in_window (in_window)
    );
`else
    logic [2*APB_AW-1:0] unused_win;
    assign unused_win = {WIN_BASE, WIN_SIZE};
    assign in_window  = 1'b1;
`endif

    // Zero-extend or truncate the captured APB address to the OBI width.
    always_comb begin
        addr_ext         = '0;
        addr_ext[CW-1:0] = addr_q[CW-1:0];
    end

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Captures the APB request in IDLE and the OBI response in RSP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (setup) begin
                    addr_q  <= APB_PADDR;
                    we_q    <= APB_PWRITE;
                    wdata_q <= APB_PWDATA;
                    strb_q  <= APB_PSTRB;
                    rdata_q <= '0;
                    err_q   <= !in_window;
                end
                RSP: if (obi_rvalid) begin
                    rdata_q <= (!we_q && !obi_err) ? obi_rdata : '0;
                    err_q   <= obi_err;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic and all outputs, which are zero unless the state drives them.
    always_comb begin
        state_d     = state_q;
        obi_req     = 1'b0;
        obi_addr    = '0;
        obi_we      = 1'b0;
        obi_be      = '0;
        obi_wdata   = '0;
        obi_rready  = 1'b0;
        APB_PREADY  = 1'b0;
        APB_PRDATA  = '0;
        APB_PSLVERR = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup) state_d = in_window ? REQ : DONE;
            end
            REQ: begin
                obi_req   = 1'b1;
                obi_addr  = addr_ext;
                obi_we    = we_q;
                obi_be    = we_q ? strb_q : '1;
                obi_wdata = wdata_q;
                if (obi_gnt) state_d = RSP;
            end
            RSP: begin
                obi_rready = 1'b1;
                if (obi_rvalid) state_d = DONE;
            end
            DONE: begin
                APB_PREADY  = 1'b1;
                APB_PRDATA  = rdata_q;
                APB_PSLVERR = err_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_to_obi_bridge.sv
// Directed self-checking bench for apb_to_obi_bridge. The window test
// follows APB_TO_OBI_WIN_CHECK_EN the same way the design does.
module tb_apb_to_obi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] APB_PADDR;
    logic        APB_PSEL;
    logic        APB_PENABLE;
    logic        APB_PWRITE;
    logic [31:0] APB_PWDATA;
    logic [3:0]  APB_PSTRB;
    logic [31:0] APB_PRDATA;
    logic        APB_PREADY;
    logic        APB_PSLVERR;
    logic        obi_req;
    logic        obi_gnt;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic [0:0]  obi_aid;
    logic        obi_rvalid;
    logic        obi_rready;
    logic [31:0] obi_rdata;
    logic        obi_err;
    logic [0:0]  obi_rid;

    int checks = 0;
    int errors = 0;
    int grant_count = 0;
    bit req_seen = 1'b0;

    apb_to_obi_bridge dut (
        .clk         (clk),
        .reset       (reset),
        .APB_PADDR   (APB_PADDR),
        .APB_PSEL    (APB_PSEL),
        .APB_PENABLE (APB_PENABLE),
        .APB_PWRITE  (APB_PWRITE),
        .APB_PWDATA  (APB_PWDATA),
        .APB_PSTRB   (APB_PSTRB),
        .APB_PRDATA  (APB_PRDATA),
        .APB_PREADY  (APB_PREADY),
        .APB_PSLVERR (APB_PSLVERR),
        .obi_req     (obi_req),
        .obi_gnt     (obi_gnt),
        .obi_addr    (obi_addr),
        .obi_we      (obi_we),
        .obi_be      (obi_be),
        .obi_wdata   (obi_wdata),
        .obi_aid     (obi_aid),
        .obi_rvalid  (obi_rvalid),
        .obi_rready  (obi_rready),
        .obi_rdata   (obi_rdata),
        .obi_err     (obi_err),
        .obi_rid     (obi_rid)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Counts OBI address handshakes and notes any request seen.
    always @(posedge clk) begin
        if (!reset && obi_req && obi_gnt) grant_count++;
        if (obi_req) req_seen = 1'b1;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_setup(input logic [31:0] addr, input logic wr,
                             input logic [31:0] wd, input logic [3:0] st);
        APB_PSEL    = 1'b1;
        APB_PENABLE = 1'b0;
        APB_PADDR   = addr;
        APB_PWRITE  = wr;
        APB_PWDATA  = wd;
        APB_PSTRB   = st;
    endtask

    task automatic apb_idle();
        APB_PSEL    = 1'b0;
        APB_PENABLE = 1'b0;
        APB_PWRITE  = 1'b0;
        APB_PADDR   = '0;
        APB_PWDATA  = '0;
        APB_PSTRB   = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apb_idle();
        obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = '0; obi_err = 1'b0; obi_rid = '0;
        step();
        apb_setup(32'h0103_0010, 1'b0, '0, 4'h0);
        step();
        checks++;
        if ({obi_req, obi_rready, APB_PREADY, APB_PSLVERR, obi_we} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                     {obi_req, obi_rready, APB_PREADY, APB_PSLVERR, obi_we});
        end
        checks++;
        if ({obi_addr, obi_wdata, obi_be, obi_aid, APB_PRDATA} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: addr %h wdata %h be %h aid %h prdata %h expected all 0",
                     obi_addr, obi_wdata, obi_be, obi_aid, APB_PRDATA);
        end
        reset = 1'b0;
        apb_idle();
        step();
        checks++;
        if (obi_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle_req: got %b expected 0", obi_req);
        end
    endtask

    task automatic test_read_basic();
        apb_setup(32'h0103_0010, 1'b0, '0, 4'h0);
        step();
        APB_PENABLE = 1'b1;
        checks++;
        if ({obi_req, obi_we, obi_be, obi_aid, APB_PREADY} !== {1'b1, 1'b0, 4'hF, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rd_req_ctrl: req %b we %b be %h aid %b pready %b expected 1 0 f 0 0",
                     obi_req, obi_we, obi_be, obi_aid, APB_PREADY);
        end
        checks++;
        if (obi_addr !== 32'h0103_0010) begin
            errors++;
            $display("[TB] FAIL rd_addr: got %h expected 01030010", obi_addr);
        end
        obi_gnt = 1'b1;
        step();
        obi_gnt = 1'b0;
        checks++;
        if ({obi_req, obi_rready, APB_PREADY} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL rd_rsp_phase: req %b rready %b pready %b expected 0 1 0",
                     obi_req, obi_rready, APB_PREADY);
        end
        obi_rvalid = 1'b1;
        obi_rdata  = 32'hDEAD_BEEF;
        step();
        obi_rvalid = 1'b0;
        obi_rdata  = '0;
        checks++;
        if ({APB_PREADY, APB_PSLVERR, obi_rready} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL rd_done_ctrl: pready %b pslverr %b rready %b expected 1 0 0",
                     APB_PREADY, APB_PSLVERR, obi_rready);
        end
        checks++;
        if (APB_PRDATA !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL rd_prdata: got %h expected deadbeef", APB_PRDATA);
        end
        apb_idle();
        step();
        checks++;
        if ({APB_PREADY, APB_PRDATA} !== 33'b0) begin
            errors++;
            $display("[TB] FAIL rd_after_done: pready %b prdata %h expected 0 0", APB_PREADY, APB_PRDATA);
        end
    endtask

    task automatic test_write_gnt_wait();
        apb_setup(32'h0103_0020, 1'b1, 32'h1234_5678, 4'b0011);
        step();
        APB_PENABLE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({obi_req, obi_we, obi_be, obi_addr, obi_wdata, APB_PREADY} !==
                {1'b1, 1'b1, 4'b0011, 32'h0103_0020, 32'h1234_5678, 1'b0}) begin
                errors++;
                $display("[TB] FAIL wr_wait_%0d: req %b we %b be %b addr %h wdata %h pready %b expected 1 1 0011 01030020 12345678 0",
                         i, obi_req, obi_we, obi_be, obi_addr, obi_wdata, APB_PREADY);
            end
            step();
        end
        checks++;
        if (obi_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wr_req_held: got %b expected 1", obi_req);
        end
        obi_gnt = 1'b1;
        step();
        obi_gnt = 1'b0;
        checks++;
        if ({obi_req, obi_rready, APB_PREADY} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL wr_rsp_phase: req %b rready %b pready %b expected 0 1 0",
                     obi_req, obi_rready, APB_PREADY);
        end
        obi_rvalid = 1'b1;
        obi_rdata  = 32'hCAFE_F00D;
        step();
        obi_rvalid = 1'b0;
        obi_rdata  = '0;
        checks++;
        if ({APB_PREADY, APB_PSLVERR, APB_PRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL wr_done: pready %b pslverr %b prdata %h expected 1 0 00000000",
                     APB_PREADY, APB_PSLVERR, APB_PRDATA);
        end
        apb_idle();
        step();
    endtask

    task automatic test_read_error();
        apb_setup(32'h0103_0030, 1'b0, '0, 4'h0);
        step();
        APB_PENABLE = 1'b1;
        obi_gnt = 1'b1;
        step();
        obi_gnt = 1'b0;
        obi_rvalid = 1'b1;
        obi_err    = 1'b1;
        obi_rdata  = 32'hA5A5_A5A5;
        step();
        obi_rvalid = 1'b0;
        obi_err    = 1'b0;
        obi_rdata  = '0;
        checks++;
        if ({APB_PREADY, APB_PSLVERR, APB_PRDATA} !== {1'b1, 1'b1, 32'h0}) begin
            errors++;
            $display("[TB] FAIL err_done: pready %b pslverr %b prdata %h expected 1 1 00000000",
                     APB_PREADY, APB_PSLVERR, APB_PRDATA);
        end
        apb_idle();
        step();
        checks++;
        if (APB_PSLVERR !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_cleared: got %b expected 0", APB_PSLVERR);
        end
    endtask

    task automatic test_back_to_back();
        int g0;
        g0 = grant_count;
        apb_setup(32'h0103_0040, 1'b0, '0, 4'h0);
        step();
        APB_PENABLE = 1'b1;
        obi_gnt = 1'b1;
        step();
        obi_gnt = 1'b0;
        obi_rvalid = 1'b1;
        obi_rdata  = 32'h1122_3344;
        step();
        obi_rvalid = 1'b0;
        obi_rdata  = '0;
        checks++;
        if ({APB_PREADY, APB_PRDATA} !== {1'b1, 32'h1122_3344}) begin
            errors++;
            $display("[TB] FAIL b2b_first: pready %b prdata %h expected 1 11223344", APB_PREADY, APB_PRDATA);
        end
        step();
        checks++;
        if ({obi_req, APB_PREADY} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL b2b_gap: req %b pready %b expected 0 0", obi_req, APB_PREADY);
        end
        apb_setup(32'h0103_0044, 1'b0, '0, 4'h0);
        step();
        APB_PENABLE = 1'b1;
        checks++;
        if ({obi_req, obi_addr} !== {1'b1, 32'h0103_0044}) begin
            errors++;
            $display("[TB] FAIL b2b_second_req: req %b addr %h expected 1 01030044", obi_req, obi_addr);
        end
        obi_gnt = 1'b1;
        step();
        obi_gnt = 1'b0;
        obi_rvalid = 1'b1;
        obi_rdata  = 32'h5566_7788;
        step();
        obi_rvalid = 1'b0;
        obi_rdata  = '0;
        checks++;
        if ({APB_PREADY, APB_PRDATA} !== {1'b1, 32'h5566_7788}) begin
            errors++;
            $display("[TB] FAIL b2b_second: pready %b prdata %h expected 1 55667788", APB_PREADY, APB_PRDATA);
        end
        apb_idle();
        step();
        checks++;
        if (grant_count - g0 !== 2) begin
            errors++;
            $display("[TB] FAIL b2b_grants: got %0d expected 2", grant_count - g0);
        end
    endtask

    task automatic test_reset_in_rsp();
        apb_setup(32'h0103_0050, 1'b0, '0, 4'h0);
        step();
        APB_PENABLE = 1'b1;
        obi_gnt = 1'b1;
        step();
        obi_gnt = 1'b0;
        checks++;
        if (obi_rready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_pre_rsp: rready %b expected 1", obi_rready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({obi_rready, obi_req, APB_PREADY, APB_PSLVERR, APB_PRDATA, obi_addr} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_async: rready %b req %b pready %b pslverr %b prdata %h addr %h expected all 0",
                     obi_rready, obi_req, APB_PREADY, APB_PSLVERR, APB_PRDATA, obi_addr);
        end
        apb_idle();
        step();
        reset = 1'b0;
        step();
        checks++;
        if ({obi_req, obi_rready, APB_PREADY} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL rst_idle: req %b rready %b pready %b expected 0 0 0", obi_req, obi_rready, APB_PREADY);
        end
        apb_setup(32'h0103_0060, 1'b0, '0, 4'h0);
        step();
        APB_PENABLE = 1'b1;
        checks++;
        if ({obi_req, obi_addr} !== {1'b1, 32'h0103_0060}) begin
            errors++;
            $display("[TB] FAIL rst_next_req: req %b addr %h expected 1 01030060", obi_req, obi_addr);
        end
        obi_gnt = 1'b1;
        step();
        obi_gnt = 1'b0;
        obi_rvalid = 1'b1;
        obi_rdata  = 32'h0BAD_F00D;
        step();
        obi_rvalid = 1'b0;
        obi_rdata  = '0;
        checks++;
        if ({APB_PREADY, APB_PSLVERR, APB_PRDATA} !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin
            errors++;
            $display("[TB] FAIL rst_next_done: pready %b pslverr %b prdata %h expected 1 0 0badf00d",
                     APB_PREADY, APB_PSLVERR, APB_PRDATA);
        end
        apb_idle();
        step();
    endtask

    task automatic test_window();
`ifdef APB_TO_OBI_WIN_CHECK_EN
        req_seen = 1'b0;
        apb_setup(32'h0103_0400, 1'b0, '0, 4'h0);
        step();
        APB_PENABLE = 1'b1;
        checks++;
        if ({APB_PREADY, APB_PSLVERR, APB_PRDATA, obi_req} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL win_reject: pready %b pslverr %b prdata %h req %b expected 1 1 00000000 0",
                     APB_PREADY, APB_PSLVERR, APB_PRDATA, obi_req);
        end
        apb_idle();
        step();
        checks++;
        if ({req_seen, APB_PREADY} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL win_no_req: req_seen %b pready %b expected 0 0", req_seen, APB_PREADY);
        end
`else
        apb_setup(32'h0103_0400, 1'b0, '0, 4'h0);
        step();
        APB_PENABLE = 1'b1;
        checks++;
        if ({obi_req, obi_addr, APB_PREADY} !== {1'b1, 32'h0103_0400, 1'b0}) begin
            errors++;
            $display("[TB] FAIL nowin_fwd: req %b addr %h pready %b expected 1 01030400 0",
                     obi_req, obi_addr, APB_PREADY);
        end
        obi_gnt = 1'b1;
        step();
        obi_gnt = 1'b0;
        obi_rvalid = 1'b1;
        obi_rdata  = 32'h7777_8888;
        step();
        obi_rvalid = 1'b0;
        obi_rdata  = '0;
        checks++;
        if ({APB_PREADY, APB_PSLVERR, APB_PRDATA} !== {1'b1, 1'b0, 32'h7777_8888}) begin
            errors++;
            $display("[TB] FAIL nowin_done: pready %b pslverr %b prdata %h expected 1 0 77778888",
                     APB_PREADY, APB_PSLVERR, APB_PRDATA);
        end
        apb_idle();
        step();
`endif
        apb_setup(32'h0103_03FC, 1'b0, '0, 4'h0);
        step();
        APB_PENABLE = 1'b1;
        checks++;
        if ({obi_req, obi_addr, APB_PREADY} !== {1'b1, 32'h0103_03FC, 1'b0}) begin
            errors++;
            $display("[TB] FAIL win_edge_fwd: req %b addr %h pready %b expected 1 010303fc 0",
                     obi_req, obi_addr, APB_PREADY);
        end
        obi_gnt = 1'b1;
        step();
        obi_gnt = 1'b0;
        obi_rvalid = 1'b1;
        obi_rdata  = 32'h99AA_BBCC;
        step();
        obi_rvalid = 1'b0;
        obi_rdata  = '0;
        checks++;
        if ({APB_PREADY, APB_PSLVERR, APB_PRDATA} !== {1'b1, 1'b0, 32'h99AA_BBCC}) begin
            errors++;
            $display("[TB] FAIL win_edge_done: pready %b pslverr %b prdata %h expected 1 0 99aabbcc",
                     APB_PREADY, APB_PSLVERR, APB_PRDATA);
        end
        apb_idle();
        step();
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        test_reset();
        test_read_basic();
        test_write_gnt_wait();
        test_read_error();
        test_back_to_back();
        test_reset_in_rsp();
        test_window();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
